// File: rtl/sseg_pkg.sv
// sseg_pkg: shared definitions for the seven-segment scan driver.
//   state_t   - per-slot scan phase (blanking guard, then digit drive)
//   SEG_TABLE - active-low {g,f,e,d,c,b,a} pattern for each hex digit
//   SEG_BLANK - cathode pattern with every segment and the point dark
//   AN_OFF    - anode pattern with every digit deselected
package sseg_pkg;

  typedef enum logic {
    ST_GUARD = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [3:0] AN_OFF    = 4'hF;

  // Entry n is the pattern for hex digit n (the list runs from F down to 0).
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/sseg_hex_decode.sv
// sseg_hex_decode: combinational hex-nibble to seven-segment decoder.
//   nibble - hex digit to show
//   segs   - active-low cathodes {g,f,e,d,c,b,a}
module sseg_hex_decode
  import sseg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segs
);

  assign segs = SEG_TABLE[nibble];

endmodule

// File: rtl/sseg_scan_driver.sv
// sseg_scan_driver: four-digit multiplexed seven-segment display controller.
// Each digit gets a slot of CLK_DIV cycles: GUARD cycles with every anode off
// (so the previous digit's cathodes never ghost onto the next one), then the
// digit is driven for the remainder of the slot.
//   CLK     - system clock
//   RESET   - synchronous, active-high reset
//   WR      - one-cycle load strobe for DATA_IN / DP_IN
//   DATA_IN - four hex nibbles, nibble n shown on digit n (digit 0 rightmost)
//   DP_IN   - decimal-point mask, bit n lights the point of digit n
//   EN      - display enable level; low darkens the display, scan keeps running
//   SEGS    - active-low cathodes, [7] = DP, [6:0] = {g,f,e,d,c,b,a}
//   AN      - active-low anodes, AN[n] selects digit n
module sseg_scan_driver
  import sseg_pkg::*;
#(
  parameter int CLK_DIV  = 50000,
  parameter int GUARD    = 16,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        WR,
  input  logic [15:0] DATA_IN,
  input  logic [3:0]  DP_IN,
  input  logic        EN,
  output logic [7:0]  SEGS,
  output logic [3:0]  AN
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] slot_cnt;
  logic [1:0]    idx;
  state_t        state;
  logic [15:0]   value;
  logic [3:0]    dp;

  logic [3:0]    nibble;
  logic [6:0]    seg_code;
  logic          blank;
  logic          slot_end;

  assign nibble   = value[{idx, 2'b00} +: 4];
  assign slot_end = (slot_cnt == CW'(CLK_DIV - 1));

  sseg_hex_decode u_decode (
    .nibble (nibble),
    .segs   (seg_code)
  );

  // A digit is a leading zero when it and every more significant nibble are
  // zero; digit 0 is always shown so a zero value still displays "0".
  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    blank = 1'b0;
    if (BLANK_LZ) begin
      case (idx)
        2'd3:    blank = (value[15:12] == 4'h0);
        2'd2:    blank = (value[15:8]  == 8'h00);
        2'd1:    blank = (value[15:4]  == 12'h000);
        default: blank = 1'b0;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      slot_cnt <= '0;
      idx      <= 2'd0;
      state    <= ST_GUARD;
      value    <= 16'h0000;
      dp       <= 4'h0;
      SEGS     <= SEG_BLANK;
      AN       <= AN_OFF;
    end else begin
      if (WR) begin
        value <= DATA_IN;
        dp    <= DP_IN;
      end

      // The slot timebase free-runs regardless of EN so the scan schedule is
      // never shifted by disabling the display.
      if (slot_end) begin
        slot_cnt <= '0;
        idx      <= idx + 2'd1;
      end else begin
        slot_cnt <= slot_cnt + 1'b1;
      end

      case (state)
        ST_GUARD: if (slot_cnt == CW'(GUARD - 1)) state <= ST_DRIVE;
        ST_DRIVE: if (slot_end)                   state <= ST_GUARD;
      endcase

      // Outputs are registered from the current phase, so they trail the
      // counter by one cycle and can never overlap two digits.
      if (state == ST_DRIVE && EN && !blank) begin
        AN   <= ~(4'b0001 << idx);
        SEGS <= {~dp[idx], seg_code};
      end else begin
        AN   <= AN_OFF;
        SEGS <= SEG_BLANK;
      end
    end
  end

endmodule

// File: tb/tb_sseg_scan_driver.sv
// tb_sseg_scan_driver: self-checking bench for sseg_scan_driver with
// CLK_DIV = 8, GUARD = 2, BLANK_LZ = 1. A timeline model predicts every
// output cycle; a vector table and hand sequences check fixed patterns.
module tb_sseg_scan_driver;

  localparam int CLK_DIV = 8;
  localparam int GUARD   = 2;

  logic        CLK;
  logic        RESET;
  logic        WR;
  logic [15:0] DATA_IN;
  logic [3:0]  DP_IN;
  logic        EN;
  logic [7:0]  SEGS;
  logic [3:0]  AN;

  int checks   = 0;
  int failures = 0;

  sseg_scan_driver #(
    .CLK_DIV  (CLK_DIV),
    .GUARD    (GUARD),
    .BLANK_LZ (1'b1)
  ) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .WR      (WR),
    .DATA_IN (DATA_IN),
    .DP_IN   (DP_IN),
    .EN      (EN),
    .SEGS    (SEGS),
    .AN      (AN)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Digit patterns written out from the decode list, index = hex value.
  logic [6:0] seg_ref [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic bit lz_blank(input logic [15:0] v, input int d);
    return (d != 0) && ((v >> (4 * d)) == 16'h0000);
  endfunction

  // Timeline model: n = edges since the last reset edge. The edge with index
  // n lands in slot (n / CLK_DIV) mod 4 at offset n mod CLK_DIV.
  bit          mvalid   = 1'b0;
  int          n        = 0;
  int          last_pos = -1;
  int          last_dig = -1;
  logic [15:0] m_val;
  logic [3:0]  m_dp;
  logic [3:0]  exp_an;
  logic [7:0]  exp_segs;

  always @(posedge CLK) begin
    logic [3:0] sel;
    int         nib;
    if (RESET) begin
      mvalid   = 1'b1;
      n        = 0;
      m_val    = 16'h0000;
      m_dp     = 4'h0;
      exp_an   = 4'hF;
      exp_segs = 8'hFF;
      last_pos = -1;
      last_dig = -1;
    end else if (mvalid) begin
      last_pos = n % CLK_DIV;
      last_dig = (n / CLK_DIV) % 4;
      if (EN && last_pos >= GUARD && !lz_blank(m_val, last_dig)) begin
        sel      = 4'd1 << last_dig;
        nib      = int'((m_val >> (4 * last_dig)) & 16'h000F);
        exp_an   = ~sel;
        exp_segs = {~m_dp[last_dig], seg_ref[nib]};
      end else begin
        exp_an   = 4'hF;
        exp_segs = 8'hFF;
      end
      n++;
      if (WR) begin
        m_val = DATA_IN;
        m_dp  = DP_IN;
      end
    end
  end

  // Every cycle: compare against the model and require at most one lit anode.
  always @(negedge CLK) begin
    if (mvalid) begin
      check("scan_an", AN, exp_an);
      check("scan_segs", SEGS, exp_segs);
      check("one_cold_an", int'($countones(~AN) <= 1), 1);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_write(input logic [15:0] d, input logic [3:0] p);
    @(negedge CLK);
    WR      = 1'b1;
    DATA_IN = d;
    DP_IN   = p;
    @(negedge CLK);
    WR      = 1'b0;
  endtask

  // Stop at the negedge whose outputs came from offset GUARD+1 of digit d.
  task automatic wait_slot(input int d);
    bit found = 1'b0;
    for (int i = 0; i < 8 * CLK_DIV; i++) begin
      @(negedge CLK);
      if (last_dig == d && last_pos == GUARD + 1) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      checks++;
      failures++;
      $display("FAIL wait_slot: digit %0d drive phase not reached within budget", d);
    end
  endtask

  typedef struct {
    bit          wr;
    logic [15:0] data;
    logic [3:0]  dp;
    int          dig;
    logic [3:0]  an;
    logic [7:0]  segs;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt_d;
    int cnt_f;

    RESET   = 1'b1;
    WR      = 1'b0;
    DATA_IN = 16'h0000;
    DP_IN   = 4'h0;
    EN      = 1'b1;

    vecs.push_back('{1'b0, 16'h0000, 4'h0,    1, 4'hF, 8'hFF});
    vecs.push_back('{1'b0, 16'h0000, 4'h0,    2, 4'hF, 8'hFF});
    vecs.push_back('{1'b0, 16'h0000, 4'h0,    3, 4'hF, 8'hFF});
    vecs.push_back('{1'b0, 16'h0000, 4'h0,    0, 4'hE, 8'hC0});
    vecs.push_back('{1'b1, 16'h0005, 4'h0,    0, 4'hE, 8'h92});
    vecs.push_back('{1'b0, 16'h0005, 4'h0,    1, 4'hF, 8'hFF});
    vecs.push_back('{1'b0, 16'h0005, 4'h0,    3, 4'hF, 8'hFF});
    vecs.push_back('{1'b1, 16'h00F0, 4'b0001, 0, 4'hE, 8'h40});
    vecs.push_back('{1'b0, 16'h00F0, 4'b0001, 1, 4'hD, 8'h8E});
    vecs.push_back('{1'b0, 16'h00F0, 4'b0001, 2, 4'hF, 8'hFF});
    vecs.push_back('{1'b1, 16'hBEEF, 4'b1111, 3, 4'h7, 8'h03});
    vecs.push_back('{1'b0, 16'hBEEF, 4'b1111, 0, 4'hE, 8'h0E});
    vecs.push_back('{1'b1, 16'h0C0D, 4'h0,    0, 4'hE, 8'hA1});
    vecs.push_back('{1'b0, 16'h0C0D, 4'h0,    1, 4'hD, 8'hC0});
    vecs.push_back('{1'b0, 16'h0C0D, 4'h0,    2, 4'hB, 8'hC6});
    vecs.push_back('{1'b0, 16'h0C0D, 4'h0,    3, 4'hF, 8'hFF});
    vecs.push_back('{1'b1, 16'h0000, 4'b1000, 3, 4'hF, 8'hFF});
    vecs.push_back('{1'b0, 16'h0000, 4'b1000, 0, 4'hE, 8'hC0});
    vecs.push_back('{1'b1, 16'h12A8, 4'b0100, 0, 4'hE, 8'h80});
    vecs.push_back('{1'b0, 16'h12A8, 4'b0100, 1, 4'hD, 8'h88});
    vecs.push_back('{1'b0, 16'h12A8, 4'b0100, 2, 4'hB, 8'h24});
    vecs.push_back('{1'b0, 16'h12A8, 4'b0100, 3, 4'h7, 8'hF9});

    // Reset, then the first lit digit three edges after release.
    repeat (2) @(negedge CLK);
    check("reset_an", AN, 4'hF);
    check("reset_segs", SEGS, 8'hFF);
    RESET = 1'b0;
    @(negedge CLK);
    check("post_reset_e1_an", AN, 4'hF);
    @(negedge CLK);
    check("post_reset_e2_an", AN, 4'hF);
    @(negedge CLK);
    check("post_reset_e3_an", AN, 4'hE);
    check("post_reset_e3_segs", SEGS, 8'hC0);

    // Vector table.
    foreach (vecs[i]) begin
      if (vecs[i].wr) do_write(vecs[i].data, vecs[i].dp);
      wait_slot(vecs[i].dig);
      check($sformatf("vec%0d_an", i), AN, vecs[i].an);
      check($sformatf("vec%0d_segs", i), SEGS, vecs[i].segs);
    end

    // One full slot of digit 1 (value 12A8): six drive cycles, then two guard.
    wait_slot(1);
    cnt_d = (AN == 4'hD) ? 1 : 0;
    cnt_f = (AN == 4'hF) ? 1 : 0;
    repeat (7) begin
      @(negedge CLK);
      if (AN == 4'hD) cnt_d++;
      if (AN == 4'hF) cnt_f++;
    end
    check("drive_len_from_pos2", cnt_d + 1, 6);
    check("guard_len_after_drive", cnt_f, 2);

    // EN low for five cycles mid-drive of digit 2, schedule must not shift.
    wait_slot(2);
    EN = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check($sformatf("en_off%0d_an", i), AN, 4'hF);
      check($sformatf("en_off%0d_segs", i), SEGS, 8'hFF);
    end
    EN = 1'b1;
    @(negedge CLK);
    check("en_resume_guard_an", AN, 4'hF);
    @(negedge CLK);
    check("en_resume_an", AN, 4'h7);
    check("en_resume_segs", SEGS, 8'hF9);

    // Write FFFF mid-drive of digit 2: the edge after the load shows F.
    wait_slot(2);
    WR      = 1'b1;
    DATA_IN = 16'hFFFF;
    DP_IN   = 4'h0;
    @(negedge CLK);
    WR = 1'b0;
    @(negedge CLK);
    check("wr_mid_drive_an", AN, 4'hB);
    check("wr_mid_drive_segs", SEGS, 8'h8E);

    // Back-to-back writes: the last one wins.
    @(negedge CLK);
    WR      = 1'b1;
    DATA_IN = 16'h0003;
    DP_IN   = 4'h0;
    @(negedge CLK);
    DATA_IN = 16'h0007;
    @(negedge CLK);
    WR = 1'b0;
    wait_slot(0);
    check("b2b_write_segs", SEGS, 8'hF8);

    // One-cycle reset mid-slot: outputs dark, value cleared, fresh guard.
    wait_slot(1);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    check("mid_reset_an", AN, 4'hF);
    check("mid_reset_segs", SEGS, 8'hFF);
    @(negedge CLK);
    check("mid_reset_e1_an", AN, 4'hF);
    @(negedge CLK);
    check("mid_reset_e2_an", AN, 4'hF);
    @(negedge CLK);
    check("mid_reset_e3_an", AN, 4'hE);
    check("mid_reset_e3_segs", SEGS, 8'hC0);

    // Randomized traffic; the model checks every cycle.
    for (int i = 0; i < 1500; i++) begin
      @(negedge CLK);
      WR = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 3))
        0:       DATA_IN = 16'($urandom);
        1:       DATA_IN = 16'($urandom_range(0, 15));
        2:       DATA_IN = 16'($urandom_range(0, 255));
        default: DATA_IN = 16'($urandom_range(0, 4095));
      endcase
      DP_IN = 4'($urandom);
      EN    = ($urandom_range(0, 15) != 0);
      RESET = ($urandom_range(0, 299) == 0);
    end
    @(negedge CLK);
    WR    = 1'b0;
    RESET = 1'b0;
    EN    = 1'b1;
    repeat (4 * CLK_DIV) @(negedge CLK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sseg_scan_driver.md
Name: sseg_scan_driver

Overview:
- Memory-mapped seven-segment display controller. It sits downstream of the MCU I/O bus write decode.
- Software writes a 16-bit hex value and a 4-bit decimal-point mask. The block time-multiplexes the four digits onto the board's active-low cathode and anode pins.
- It replaces the raw software-driven segment and anode registers. The CPU no longer bit-bangs the scan.

Parameters:
- CLK_DIV, 50000: CLK cycles per digit slot (1 ms at 50 MHz). Must be > GUARD + 1.
- GUARD, 16: cycles at the start of each slot with all anodes off (anti-ghosting). Must be ≥ 1.
- BLANK_LZ, 1: 1 = blank leading-zero digits; 0 = always show all four digits.

Ports:
- CLK  in  1  system clock (50 MHz domain).
- RESET  in  1  synchronous, active-high reset.
- WR  in  1  load strobe, one cycle. Asserted when the bus writes the display data address.
- DATA_IN  in  16  hex value; nibble n drives digit n (digit 0 = rightmost).
- DP_IN  in  4  decimal-point mask, sampled with WR; 1 = point lit on digit n.
- EN  in  1  display enable (level).
- SEGS  out  8  cathodes, active low; [7] = DP, [6:0] = {g,f,e,d,c,b,a}.
- AN  out  4  anodes, active low; AN[n] selects digit n.

Behaviour:
- Clock and reset: single clock CLK. RESET is synchronous, active-high.
- Reset values: SEGS = 8'hFF, AN = 4'hF, value register = 16'h0000, dp register = 4'h0, slot counter = 0, digit index = 0, state = GUARD. RESET mid-slot aborts the slot; digit 0 restarts with a full guard.
- Load path:
  - WR = 1 at edge k loads DATA_IN/DP_IN.
  - Outputs reflect the new value at edge k+1 if that digit is being driven.
  - WR is ignored while RESET is high.
  - Back-to-back WR: the last write wins.
- Slot counter: counts 0..CLK_DIV-1 every cycle regardless of EN. At CLK_DIV-1 it wraps to 0 and digit index advances 0→1→2→3→0.
- State machine (per slot):
  - GUARD: counter < GUARD. Next AN = 4'hF, next SEGS = 8'hFF. Transition to DRIVE when counter == GUARD-1.
  - DRIVE: next AN = one-cold on the digit index. Next SEGS = {~dp[idx], decode(nibble[idx])}. Transition to GUARD when counter == CLK_DIV-1, with the index incremented.
- Outputs are registered: AN/SEGS lag the state/counter by exactly one cycle.
- Decode (active low, {g..a}):
  - 0 = 40, 1 = 79, 2 = 24, 3 = 30, 4 = 19, 5 = 12, 6 = 02, 7 = 78
  - 8 = 00, 9 = 10, A = 08, b = 03, C = 46, d = 21, E = 06, F = 0E (hex, 7-bit)
- Leading-zero blank (BLANK_LZ = 1):
  - Digit 3 is blank if nib3 = 0.
  - Digit 2 is blank if nib3 = nib2 = 0.
  - Digit 1 is blank if nib3..nib1 = 0.
  - Digit 0 is never blank.
  - A blanked digit gives AN = 4'hF and SEGS = 8'hFF for the whole slot, even if its dp bit is set.
- EN = 0: AN forced 4'hF and SEGS forced 8'hFF on the next edge. Counter and index keep running. Re-enabling mid-slot resumes DRIVE output at the next edge.
- At most one AN bit is low at any time. There is no cycle where the previous and next digits overlap.

Decomposition:
- Package sseg_pkg:
  - state enum (GUARD, DRIVE)
  - 16-entry active-low segment constant table
  - localparams SEG_BLANK = 8'hFF and AN_OFF = 4'hF
- Sub-module sseg_hex_decode: purely combinational, 4-bit nibble → 7-bit active-low segments, using the table.
- The top module holds the counter, index, FSM, blanking logic and output registers.

Test Plan (bench uses CLK_DIV = 8, GUARD = 2, BLANK_LZ = 1):
- Reset then idle → AN = F, SEGS = FF during reset. The first AN = E appears 3 edges after RESET deasserts. Digits 1–3 stay blank (value 0). Digit 0 shows SEGS = C0.
- WR DATA_IN = 16'h12A8, DP_IN = 4'b0100 → per slot (DRIVE phase):
  - AN = E, SEGS = 80
  - AN = D, SEGS = 88
  - AN = B, SEGS = 24 (dp lit)
  - AN = 7, SEGS = F9
  - Each DRIVE phase lasts 6 cycles and is preceded by 2 cycles of AN = F.
- WR 16'h0005 → only digit 0 is lit (SEGS = 92). Slots 1–3 show AN = F throughout.
- EN low for 5 cycles during a DRIVE slot → AN = F from the next edge. Output resumes at the correct index afterwards; the slot schedule is unshifted.
- WR 16'hFFFF mid-DRIVE of digit 2 → the next edge shows SEGS = 8E on AN = B. The assertion that no AN pattern has more than one zero bit holds throughout.
- RESET asserted mid-slot for 1 cycle → the next edge gives AN = F, SEGS = FF, value = 0, and digit 0 starts a fresh guard phase.
